risc16_mc_control: RTL and testbench

- Multi-cycle control sequencer for the 16-bit RiSC-16 datapath (8 × 16-bit registers, 3-bit opcode, 4-bit ALU op).
- Walks each instruction through FETCH, DECODE, EXEC, MEM and WB.
- Drives all datapath control strobes and PC update selects.
- Owns the single memory port handshake for both instruction fetch and data access.

---
 rtl/risc16_mc_control.sv | 196 +++++++++++++++++++
 tb/tb_risc16_mc_control.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/risc16_mc_control.sv
// rtl/risc16_mc_control.sv - multi-cycle control sequencer for the RiSC-16 datapath (optional RISC16_PERF_EN adds perf counters)
module risc16_mc_control #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TCNT_W      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] instr,
  input  logic        alu_zero,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_load,
  output logic        pc_load,
  output logic [1:0]  pc_src,
  output logic        reg_we,
  output logic [1:0]  reg_wsel,
  output logic [3:0]  alu_op,
  output logic        alu_src,
  output logic        imm_sel,
  output logic        busy,
  output logic        retire,
  output logic        halted,
  output logic        fault
`ifdef RISC16_PERF_EN
  ,
  output logic [31:0] retired_cnt,
  output logic [31:0] stall_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, FAULT} state_t;

  localparam bit                TO_EN  = (MEM_TIMEOUT != 0);
  localparam logic [TCNT_W-1:0] TLIMIT = TCNT_W'(MEM_TIMEOUT - 1);

  state_t            state, state_nx;
  logic [TCNT_W-1:0] tcnt, tcnt_nx;
  logic [2:0]        opcode;
  logic              dest_r0;
  logic              jalr_halt;
  logic              wait_mem;
  logic              timeout_hit;
  logic              reg_we_raw;
  logic [3:0]        alu_op_dec;
  logic              alu_src_dec;
  logic              imm_sel_dec;
  logic              unused_bits;

  assign opcode      = instr[15:13];
  assign dest_r0     = (instr[12:10] == 3'b000);
  assign jalr_halt   = |instr[6:0];
  assign unused_bits = ^instr[9:7];

  // A request is outstanding in FETCH/MEM until acked; derived from state to avoid a comb loop
  assign wait_mem    = ((state == FETCH) || (state == MEM)) && !mem_ack;
  // The cycle whose unacked count would reach MEM_TIMEOUT is the last one allowed
  assign timeout_hit = TO_EN && wait_mem && (tcnt == TLIMIT);
  assign tcnt_nx     = wait_mem ? tcnt + TCNT_W'(1) : '0;

  assign busy   = !((state == IDLE) || (state == HALT) || (state == FAULT));
  assign halted = (state == HALT);
  assign fault  = (state == FAULT);
  // Writes to r0 are suppressed here so every write path shares one guard
  assign reg_we = reg_we_raw && !dest_r0;

  // ALU controls per opcode; EXEC drives them and MEM/WB hold them
  always_comb begin
    alu_op_dec  = 4'b0000;
    alu_src_dec = 1'b0;
    imm_sel_dec = 1'b0;
    case (opcode)
      3'b000: alu_op_dec = 4'b0001;
      3'b001: begin alu_op_dec = 4'b0001; alu_src_dec = 1'b1; end
      3'b010: alu_op_dec = 4'b0010;
      3'b011: begin alu_op_dec = 4'b0011; alu_src_dec = 1'b1; imm_sel_dec = 1'b1; end
      3'b100, 3'b101: begin alu_op_dec = 4'b0000; alu_src_dec = 1'b1; end
      3'b110: alu_op_dec = 4'b0100;
      default: alu_op_dec = 4'b0000;
    endcase
  end

  // Next-state and strobe decode
  always_comb begin
    state_nx     = state;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_load      = 1'b0;
    pc_load      = 1'b0;
    pc_src       = 2'b00;
    reg_we_raw   = 1'b0;
    reg_wsel     = 2'b00;
    alu_op       = 4'b0000;
    alu_src      = 1'b0;
    imm_sel      = 1'b0;
    retire       = 1'b0;
    case (state)
      IDLE: if (start) state_nx = FETCH;
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_load  = 1'b1;
          state_nx = DECODE;
        end else if (timeout_hit) begin
          state_nx = FAULT;
        end
      end
      DECODE: state_nx = EXEC;
      EXEC: begin
        alu_op  = alu_op_dec;
        alu_src = alu_src_dec;
        imm_sel = imm_sel_dec;
        case (opcode)
          3'b100, 3'b101: state_nx = MEM;
          3'b110: begin
            pc_load  = 1'b1;
            pc_src   = alu_zero ? 2'b01 : 2'b00;
            retire   = 1'b1;
            state_nx = FETCH;
          end
          3'b111: begin
            if (jalr_halt) begin
              state_nx = HALT;
            end else begin
              reg_we_raw = 1'b1;
              reg_wsel   = 2'b10;
              pc_load    = 1'b1;
              pc_src     = 2'b10;
              retire     = 1'b1;
              state_nx   = FETCH;
            end
          end
          default: state_nx = WB;
        endcase
      end
      MEM: begin
        alu_op       = alu_op_dec;
        alu_src      = alu_src_dec;
        imm_sel      = imm_sel_dec;
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (opcode == 3'b100);
        if (mem_ack) begin
          pc_load = 1'b1;
          retire  = 1'b1;
          if (opcode == 3'b101) begin
            reg_we_raw = 1'b1;
            reg_wsel   = 2'b01;
          end
          state_nx = FETCH;
        end else if (timeout_hit) begin
          state_nx = FAULT;
        end
      end
      WB: begin
        alu_op     = alu_op_dec;
        alu_src    = alu_src_dec;
        imm_sel    = imm_sel_dec;
        reg_we_raw = 1'b1;
        pc_load    = 1'b1;
        retire     = 1'b1;
        state_nx   = FETCH;
      end
      HALT, FAULT: state_nx = state;
      default: state_nx = IDLE;
    endcase
  end

  // State and timeout counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      tcnt  <= '0;
    end else begin
      state <= state_nx;
      tcnt  <= tcnt_nx;
    end
  end

`ifdef RISC16_PERF_EN
  // Free-running retire and memory-stall counters, wrapping at 2^32
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      if (retire)   retired_cnt <= retired_cnt + 32'd1;
      if (wait_mem) stall_cnt   <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_risc16_mc_control.sv
// tb/tb_risc16_mc_control.sv - table-driven and randomized checks of risc16_mc_control
module tb_risc16_mc_control;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] instr = 16'h0000;
  logic        alu_zero = 1'b0;
  logic        mem_ack = 1'b0;
  logic        mem_req, mem_we, mem_addr_sel, ir_load, pc_load;
  logic [1:0]  pc_src, reg_wsel;
  logic        reg_we, alu_src, imm_sel, busy, retire, halted, fault;
  logic [3:0]  alu_op;

  always #5 clk = ~clk;

  risc16_mc_control #(.MEM_TIMEOUT(16), .TCNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .instr(instr), .alu_zero(alu_zero),
    .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .ir_load(ir_load), .pc_load(pc_load), .pc_src(pc_src), .reg_we(reg_we),
    .reg_wsel(reg_wsel), .alu_op(alu_op), .alu_src(alu_src), .imm_sel(imm_sel),
    .busy(busy), .retire(retire), .halted(halted), .fault(fault)
  );

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       ir_load;
    logic       pc_load;
    logic [1:0] pc_src;
    logic       reg_we;
    logic [1:0] reg_wsel;
    logic [3:0] alu_op;
    logic       alu_src;
    logic       imm_sel;
    logic       busy;
    logic       retire;
    logic       halted;
    logic       fault;
  } outs_t;

  typedef struct {
    logic [15:0] ins;
    int          az;
    int          fw;
    int          mw;
    int          cyc;
    logic [1:0]  src;
    logic        we;
    logic [1:0]  wsel;
  } tvec_t;

  outs_t cur, obs;
  int    n_cmp = 0;
  int    n_fail = 0;
  tvec_t tv[13];

  assign cur = {mem_req, mem_we, mem_addr_sel, ir_load, pc_load, pc_src, reg_we,
                reg_wsel, alu_op, alu_src, imm_sel, busy, retire, halted, fault};

  task automatic chk_now(input string name, input outs_t exp);
    n_cmp++;
    obs = cur;
    if (cur !== exp) begin
      n_fail++;
      $display("FAIL %s: got %05h want %05h", name, cur, exp);
    end
  endtask

  task automatic chk(input string name, input outs_t exp);
    @(negedge clk);
    chk_now(name, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_val(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  function automatic logic pick_az(input int m);
    return (m == 2) ? 1'($urandom) : (m == 1);
  endfunction

  // ALU settings an opcode needs while it executes
  function automatic outs_t alu_exp(input logic [2:0] op);
    outs_t e = '0;
    case (op)
      3'd0: e.alu_op = 4'b0001;
      3'd1: begin e.alu_op = 4'b0001; e.alu_src = 1'b1; end
      3'd2: e.alu_op = 4'b0010;
      3'd3: begin e.alu_op = 4'b0011; e.alu_src = 1'b1; e.imm_sel = 1'b1; end
      3'd4, 3'd5: begin e.alu_op = 4'b0000; e.alu_src = 1'b1; end
      3'd6: e.alu_op = 4'b0100;
      default: e.alu_op = 4'b0000;
    endcase
    return e;
  endfunction

  // Walks one instruction from its first fetch cycle, checking every cycle
  task automatic run_instr(input logic [15:0] ins, input int az_mode, input int fw,
                           input int mw, output int ncyc);
    logic [2:0] op;
    logic       wr;
    outs_t      e, a;
    op   = ins[15:13];
    wr   = (ins[12:10] != 3'd0);
    ncyc = 0;
    instr = ins;
    a = alu_exp(op);
    for (int i = 0; i <= fw; i++) begin
      mem_ack = (i == fw);
      alu_zero = pick_az(az_mode);
      e = '0; e.mem_req = 1'b1; e.busy = 1'b1; e.ir_load = (i == fw);
      chk("fetch", e);
      ncyc++;
    end
    mem_ack = 1'($urandom);
    alu_zero = pick_az(az_mode);
    e = '0; e.busy = 1'b1;
    chk("decode", e);
    ncyc++;
    mem_ack = 1'($urandom);
    alu_zero = pick_az(az_mode);
    e = a; e.busy = 1'b1;
    if (op == 3'd6) begin
      e.pc_load = 1'b1; e.retire = 1'b1; e.pc_src = alu_zero ? 2'b01 : 2'b00;
    end else if (op == 3'd7 && ins[6:0] == 7'd0) begin
      e.reg_we = wr; e.reg_wsel = 2'b10; e.pc_load = 1'b1; e.pc_src = 2'b10; e.retire = 1'b1;
    end
    chk("exec", e);
    ncyc++;
    if (op <= 3'd3) begin
      mem_ack = 1'($urandom);
      e = a; e.busy = 1'b1; e.reg_we = wr; e.pc_load = 1'b1; e.retire = 1'b1;
      chk("wb", e);
      ncyc++;
    end else if (op == 3'd4 || op == 3'd5) begin
      for (int j = 0; j <= mw; j++) begin
        mem_ack = (j == mw);
        e = a; e.busy = 1'b1; e.mem_req = 1'b1; e.mem_addr_sel = 1'b1; e.mem_we = (op == 3'd4);
        if (j == mw) begin
          e.pc_load = 1'b1; e.retire = 1'b1;
          if (op == 3'd5) begin e.reg_we = wr; e.reg_wsel = 2'b01; end
        end
        chk("mem", e);
        ncyc++;
      end
    end
  endtask

  initial begin
    int          nc;
    int          fw, mw, exp_cyc;
    logic [2:0]  op;
    logic [15:0] ins;
    outs_t       e;

    //        instr     az fw  mw cyc  pc_src we  wsel
    tv[0]  = '{16'h0503, 0, 0,  0,  4, 2'b00, 1, 2'b00};
    tv[1]  = '{16'hA885, 0, 0,  3,  7, 2'b00, 1, 2'b01};
    tv[2]  = '{16'hC482, 1, 0,  0,  3, 2'b01, 0, 2'b00};
    tv[3]  = '{16'hC482, 0, 0,  0,  3, 2'b00, 0, 2'b00};
    tv[4]  = '{16'h2001, 0, 0,  0,  4, 2'b00, 0, 2'b00};
    tv[5]  = '{16'h8885, 0, 0,  2,  6, 2'b00, 0, 2'b00};
    tv[6]  = '{16'hE400, 0, 0,  0,  3, 2'b10, 1, 2'b10};
    tv[7]  = '{16'hE000, 0, 1,  0,  4, 2'b10, 0, 2'b10};
    tv[8]  = '{16'h4503, 0, 2,  0,  6, 2'b00, 1, 2'b00};
    tv[9]  = '{16'h6BFF, 0, 0,  0,  4, 2'b00, 1, 2'b00};
    tv[10] = '{16'h0503, 0, 15, 0, 19, 2'b00, 1, 2'b00};
    tv[11] = '{16'hA885, 0, 0, 15, 19, 2'b00, 1, 2'b01};
    tv[12] = '{16'hA085, 0, 0,  0,  4, 2'b00, 0, 2'b01};

    repeat (2) @(posedge clk);
    #1;
    chk_now("reset", '0);
    rst = 1'b0;
    chk("idle", '0);
    start = 1'b1;
    chk("idle_start", '0);
    start = 1'b0;

    for (int k = 0; k < 13; k++) begin
      run_instr(tv[k].ins, tv[k].az, tv[k].fw, tv[k].mw, nc);
      chk_val("tbl_cycles", nc, tv[k].cyc);
      chk_val("tbl_pc_src", int'(obs.pc_src), int'(tv[k].src));
      chk_val("tbl_reg_we", int'(obs.reg_we), int'(tv[k].we));
      chk_val("tbl_reg_wsel", int'(obs.reg_wsel), int'(tv[k].wsel));
    end

    for (int k = 0; k < 200; k++) begin
      op  = 3'($urandom_range(0, 7));
      ins = 16'($urandom);
      ins[15:13] = op;
      if (op == 3'd7) ins[6:0] = 7'd0;
      fw = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
      mw = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
      run_instr(ins, 2, fw, mw, nc);
      exp_cyc = ((op >= 3'd6) ? 3 : 4) + fw + ((op == 3'd4 || op == 3'd5) ? mw : 0);
      chk_val("rand_cycles", nc, exp_cyc);
    end

    run_instr(16'hE071, 0, 0, 0, nc);
    chk_val("halt_no_retire", int'(obs.retire), 0);
    for (int k = 0; k < 4; k++) begin
      start = (k % 2 == 0);
      mem_ack = 1'b1;
      e = '0; e.halted = 1'b1;
      chk("halted", e);
    end
    rst = 1'b1;
    #1;
    chk_now("rst_halt", '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    start = 1'b0;
    chk("idle_after_halt", '0);

    start = 1'b1;
    chk("idle_to", '0);
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mem_ack = 1'b0;
      e = '0; e.mem_req = 1'b1; e.busy = 1'b1;
      chk("to_wait", e);
    end
    for (int k = 0; k < 3; k++) begin
      mem_ack = 1'b1;
      start = 1'b1;
      e = '0; e.fault = 1'b1;
      chk("fault", e);
    end
    rst = 1'b1;
    #1;
    chk_now("rst_fault", '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    start = 1'b0;
    chk("idle_after_fault", '0);

    start = 1'b1;
    chk("idle_mid", '0);
    start = 1'b0;
    instr = 16'hA885;
    mem_ack = 1'b1;
    e = '0; e.mem_req = 1'b1; e.busy = 1'b1; e.ir_load = 1'b1;
    chk("mid_fetch", e);
    e = '0; e.busy = 1'b1;
    chk("mid_decode", e);
    e = alu_exp(3'd5); e.busy = 1'b1;
    chk("mid_exec", e);
    mem_ack = 1'b0;
    e = alu_exp(3'd5); e.busy = 1'b1; e.mem_req = 1'b1; e.mem_addr_sel = 1'b1;
    chk("mid_mem", e);
    mem_ack = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk_now("rst_mid", '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mem_ack = 1'b0;
    chk("idle_after_mid", '0);
    chk("idle_stays", '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
